fetch_queue: RTL

- Instruction prefetch buffer between the word-addressed instruction RAM fetch port and the decode stage.
- Owns the fetch PC and issues one read per cycle while there is space to hold the result.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry FIFO.
- Hands instructions to decode over a valid/ready handshake; a redirect (branch/jump) flushes the queue and restarts fetch.

---
 rtl/fetch_queue.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues credit-limited reads to
// a one-cycle-latency instruction RAM and buffers {instruction, pc} for decode.
module fetch_queue #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31,
  parameter int DEPTH      = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  output logic                     o_fetch_req,
  output logic [ADDR_WIDTH:0]      o_read_fetch_addr,
  input  logic [DATA_WIDTH:0]      i_read_fetch_data,
  input  logic                     i_redirect,
  input  logic [ADDR_WIDTH:0]      i_redirect_pc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH:0]      o_instruction,
  output logic [ADDR_WIDTH:0]      o_instruction_pc,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH:0] fpc;
  logic [ADDR_WIDTH:0] req_pc;
  logic                inflight;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;

  logic [DATA_WIDTH:0] data_mem [DEPTH];
  logic [ADDR_WIDTH:0] pc_mem   [DEPTH];

  logic                pop;
  logic                push;
  logic [CNT_W:0]      committed;
  logic                has_credit;
  logic [CNT_W-1:0]    count_next;

  assign o_valid           = (count != '0);
  assign pop               = o_valid & i_ready;
  assign push              = inflight & ~i_redirect;
  assign o_read_fetch_addr = fpc;
  assign o_count           = count;

  // Slots already owed (queued + in flight) after this cycle's pop; a new
  // request may only go out if its response is guaranteed a slot.
  assign committed  = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign has_credit = committed < (CNT_W+1)'(DEPTH);

  assign o_fetch_req = clk_en & rst & ~i_redirect & has_credit;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (!push && pop)
      count_next = count - CNT_W'(1);
  end

  assign o_instruction    = o_valid ? data_mem[rd_ptr] : '0;
  assign o_instruction_pc = o_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc      <= (ADDR_WIDTH+1)'(RESET_PC);
      req_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (clk_en) begin
      if (i_redirect) begin
        fpc      <= i_redirect_pc;
        inflight <= 1'b0;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (o_fetch_req) begin
          fpc      <= fpc + (ADDR_WIDTH+1)'(1);
          req_pc   <= fpc;
          inflight <= 1'b1;
        end else begin
          inflight <= 1'b0;
        end
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_next;
      end
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (clk_en && push) begin
      data_mem[wr_ptr] <= i_read_fetch_data;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule
